lfsr_rr_ctrl: RTL and testbench



---
 rtl/lfsr_ctrl_pkg.sv | 25 ++
 rtl/lfsr_step_core.sv | 40 ++++
 rtl/lfsr_rr_ctrl.sv | 124 ++++++++++++
 tb/tb_lfsr_rr_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and elaboration helpers for the round-robin LFSR controller.
package lfsr_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StShift   = 2'd1,
    StDeliver = 2'd2
  } state_e;

  // Known-primitive feedback masks; other widths fall back to a minimal mask
  // that callers are expected to override.
  function automatic logic [63:0] default_taps(input int unsigned width);
    case (width)
      32'd8:   return 64'h1D;
      32'd16:  return 64'h002D;
      default: return 64'h3;
    endcase
  endfunction

  // Bits needed to count 0..steps-1.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// Fibonacci LFSR state holder: load with zero-seed substitution, or single-step on enable.
module lfsr_step_core
  import lfsr_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_en,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH-1:0] s_q, s_d;
  logic             fb;

  always_comb begin
    fb  = ^(s_q & TAPS);
    s_d = s_q;
    if (load) begin
      // An all-zero state would lock the register, so it is never loaded.
      s_d = (load_val == '0) ? WIDTH'(1) : load_val;
    end else if (step_en) begin
      s_d = {fb, s_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q <= WIDTH'(1);
    end else begin
      s_q <= s_d;
    end
  end

  assign s = s_q;

endmodule

// File: rtl/lfsr_rr_ctrl.sv
// Shares one LFSR among NREQ requesters with round-robin grants; each grant delivers a
// word after STEPS shifts. Define LFSR_FREE_RUN_EN to let the LFSR advance while idle.
module lfsr_rr_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      NREQ  = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter int unsigned      STEPS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  output logic             busy
);

  localparam int unsigned     IdxW    = $clog2(NREQ);
  localparam int unsigned     CntW    = cnt_width(STEPS);
  localparam logic [CntW-1:0] CntLast = CntW'(STEPS - 1);
  localparam logic [IdxW-1:0] PtrRst  = IdxW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win_q, win_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] rr_idx, rr_win;
  logic            rr_found;
  logic            step_en;

  // First asserted request strictly after the last winner, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = ptr_q;
    rr_idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      rr_idx = IdxW'((32'(ptr_q) + i) % NREQ);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    step_en = 1'b0;
    unique case (state_q)
      StIdle: begin
`ifdef LFSR_FREE_RUN_EN
        step_en = 1'b1;
`else
        step_en = 1'b0;
`endif
        if (rr_found) begin
          win_d   = rr_win;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        step_en = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        ptr_d   = win_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A seed load overrides everything: abort any transaction, keep the pointer.
    if (seed_load) begin
      state_d = StIdle;
      ptr_d   = ptr_q;
      step_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= PtrRst;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  lfsr_step_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (seed_load),
    .load_val (seed_val),
    .step_en  (step_en),
    .s        (rnd_data)
  );

  always_comb begin
    gnt       = '0;
    rnd_valid = (state_q == StDeliver);
    busy      = (state_q != StIdle);
    if (rnd_valid) begin
      gnt[win_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_rr_ctrl.sv
// Scoreboard bench for lfsr_rr_ctrl: transaction-level model predicts grants and words.
module tb_lfsr_rr_ctrl;

  localparam int unsigned STEPS = 8;
  localparam logic [7:0]  TAPS  = 8'h1D;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed_val = 8'h00;
  logic [3:0] req = 4'h0;
  logic [3:0] gnt;
  logic [7:0] rnd_data;
  logic       rnd_valid, busy;

  logic       seed_load1 = 1'b0;
  logic [7:0] seed_val1 = 8'h00;
  logic [3:0] req1 = 4'h0;
  logic [3:0] gnt1;
  logic [7:0] rnd_data1;
  logic       rnd_valid1, busy1;

  lfsr_rr_ctrl #(.WIDTH(8), .NREQ(4), .TAPS(TAPS), .STEPS(STEPS)) u_dut (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed_val(seed_val), .req(req),
    .gnt(gnt), .rnd_data(rnd_data), .rnd_valid(rnd_valid), .busy(busy)
  );

  lfsr_rr_ctrl #(.WIDTH(8), .NREQ(4), .TAPS(TAPS), .STEPS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load1), .seed_val(seed_val1), .req(req1),
    .gnt(gnt1), .rnd_data(rnd_data1), .rnd_valid(rnd_valid1), .busy(busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         win;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_grants = 0;
  int         last_cyc = 0;
  logic [3:0] last_gnt = 4'h0;
  logic [7:0] last_data = 8'h00;

  int         m_ptr = 3;
  int         m_win = 0;
  int         m_gcyc = 0;
  logic [7:0] m_s = 8'd1;
  bit         m_active = 1'b0;

  function automatic logic [7:0] ref_step(input logic [7:0] s);
    int fb;
    fb = $countones(s & TAPS) % 2;
    return 8'((s >> 1) + (fb << 7));
  endfunction

  function automatic logic [7:0] ref_seed(input logic [7:0] v);
    return (v == 8'h00) ? 8'd1 : v;
  endfunction

  function automatic int ref_pick(input int ptr, input logic [3:0] r);
    int j;
    for (int i = 1; i <= 4; i++) begin
      j = (ptr + i) % 4;
      if (r[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction at a time, word computed at acceptance.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s      = 8'd1;
      m_ptr    = 3;
      m_active = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      if (m_active) begin
        if (seed_load) begin
          if (cyc <= m_gcyc) void'(exp_q.pop_back());
          m_s      = ref_seed(seed_val);
          m_active = 1'b0;
        end else if (cyc == m_gcyc + 1) begin
          m_ptr    = m_win;
          m_active = 1'b0;
        end
      end else if (seed_load) begin
        m_s = ref_seed(seed_val);
      end else if (req != 4'h0) begin
        m_win  = ref_pick(m_ptr, req);
        m_gcyc = cyc + STEPS;
        for (int k = 0; k < STEPS; k++) m_s = ref_step(m_s);
        m_active = 1'b1;
        exp_q.push_back('{m_win, m_s, m_gcyc});
      end
    end
  end

  // Monitor on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      check("busy", 32'(busy), 32'(m_active));
      if (!m_active) check("idle_data", 32'(rnd_data), 32'(m_s));
      if (rnd_valid === 1'b1) begin
        n_grants++;
        last_cyc  = cyc;
        last_gnt  = gnt;
        last_data = rnd_data;
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(rnd_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_gnt", 32'(gnt), 32'd1 << e.win);
          check("sb_data", 32'(rnd_data), 32'(e.data));
          check("sb_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("gnt_idle", 32'(gnt), 32'd0);
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          check("missing_grant", 32'(rnd_valid), 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = 4'h0;
    req1      = 4'h0;
    seed_load = 1'b0;
    seed_val  = 8'h00;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_grant(input int max, input string name);
    int start;
    int t;
    start = n_grants;
    t = 0;
    while (n_grants == start && t < max) begin
      tick();
      t++;
    end
    if (n_grants == start) check({name, "_timeout"}, 32'(n_grants), 32'(start + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c0;
    int         prev;
    int         t;
    int         distinct;
    int         zeros;
    int         g0;
    logic [7:0] ms;
    logic [7:0] words[256];
    bit         seen[256];

    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(rnd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(rnd_data), 32'h01);

    // Single requester, exact latency and first two words.
    req = 4'b0001;
    c0  = cyc;
    wait_grant(20, "t1a");
    req = 4'h0;
    check("t1_gnt", 32'(last_gnt), 32'b0001);
    check("t1_data", 32'(last_data), 32'h71);
    check("t1_latency", 32'(last_cyc), 32'(c0 + 1 + STEPS));
    req = 4'b0001;
    wait_grant(20, "t1b");
    req = 4'h0;
    check("t1_data2", 32'(last_data), 32'hA4);

    // All requesting: rotation and spacing.
    do_reset();
    req  = 4'b1111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(20, "t2");
      check("t2_order", 32'(last_gnt), 32'd1 << (g % 4));
      if (g > 0) check("t2_spacing", 32'(last_cyc - prev), 32'(STEPS + 2));
      prev = last_cyc;
    end
    req = 4'h0;

    // Zero seed is replaced by one.
    seed_load = 1'b1;
    seed_val  = 8'h00;
    tick();
    seed_load = 1'b0;
    check("t3_seed", 32'(rnd_data), 32'h01);
    req = 4'b0100;
    wait_grant(20, "t3");
    req = 4'h0;
    check("t3_gnt", 32'(last_gnt), 32'b0100);
    check("t3_data", 32'(last_data), 32'h71);

    // Seed load aborts mid-shift; held request is then re-served.
    do_reset();
    req = 4'b0010;
    g0  = n_grants;
    tick();
    tick();
    tick();
    tick();
    seed_load = 1'b1;
    seed_val  = 8'h01;
    tick();
    seed_load = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_no_gnt", 32'(n_grants), 32'(g0));
    wait_grant(20, "t4a");
    req = 4'h0;
    check("t4_gnt", 32'(last_gnt), 32'b0010);
    check("t4_data", 32'(last_data), 32'h71);

    // Pointer untouched by the abort: req[0] wins next.
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    tick();
    tick();
    seed_load = 1'b1;
    seed_val  = 8'h01;
    tick();
    seed_load = 1'b0;
    req       = 4'b1111;
    wait_grant(20, "t4b");
    req = 4'h0;
    check("t4_ptr", 32'(last_gnt), 32'b0001);

    // Reset during DELIVER.
    do_reset();
    req = 4'b0001;
    t   = 0;
    while (rnd_valid !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    check("t5_reach", 32'(rnd_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_gnt", 32'(gnt), 32'd0);
    check("t5_valid", 32'(rnd_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_data", 32'(rnd_data), 32'h01);
    req = 4'h0;
    tick();
    reset_n = 1'b1;
    tick();

    // Randomized traffic with occasional seeds and mid-service drops.
    for (int c = 0; c < 600; c++) begin
      req       = (req & ~gnt) | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      seed_load = ($urandom_range(0, 39) == 0);
      seed_val  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 29) == 0) req = 4'(req & $urandom);
      tick();
    end
    req       = 4'h0;
    seed_load = 1'b0;
    for (int c = 0; c < 20; c++) tick();

    // STEPS=1 instance walks the full period.
    req1 = 4'b1000;
    ms   = 8'd1;
    for (int n = 0; n < 256; n++) begin
      t = 0;
      while (rnd_valid1 !== 1'b1 && t < 10) begin
        tick();
        t++;
      end
      if (rnd_valid1 !== 1'b1) begin
        check("t6_timeout", 32'(rnd_valid1), 32'd1);
        break;
      end
      ms = ref_step(ms);
      check("t6_word", 32'(rnd_data1), 32'(ms));
      if (n == 0) check("t6_gnt", 32'(gnt1), 32'b1000);
      words[n] = rnd_data1;
      tick();
    end
    req1 = 4'h0;
    distinct = 0;
    zeros    = 0;
    for (int n = 0; n < 256; n++) seen[n] = 1'b0;
    for (int n = 0; n < 255; n++) begin
      if (words[n] == 8'h00) zeros++;
      if (!seen[words[n]]) begin
        seen[words[n]] = 1'b1;
        distinct++;
      end
    end
    check("t6_distinct", 32'(distinct), 32'd255);
    check("t6_nonzero", 32'(zeros), 32'd0);
    check("t6_first", 32'(words[0]), 32'h80);
    check("t6_wrap", 32'(words[255]), 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
